// File: rtl/west_skew_feeder.sv
// west_skew_feeder
//   Feeds one activation per row into the west edge of a PE grid, skewing
//   row r by r+1 cycles so the wavefront lines up diagonally across the
//   array. A small FSM tracks a tile from its first beat through the drain
//   of the skew pipeline and pulses o_done once the last slice has left.
//
// Ports
//   i_clk        clock, all state on rising edge
//   i_rst_n      asynchronous active-low reset
//   i_valid      input beat valid
//   i_data       ROWS x DATA_W activations, row 0 in the most significant slice
//   i_last       final beat of the tile (sampled on accepted beats only)
//   o_ready      feeder can accept a beat this cycle
//   o_west_data  ROWS x {row_valid, activation}, row 0 in the most significant slice
//   o_busy       tile in progress (streaming or draining)
//   o_done       one-cycle pulse after the tile has fully left the feeder
module west_skew_feeder #(
  parameter int ROWS   = 9,
  parameter int DATA_W = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  input  logic [ROWS*DATA_W-1:0]     i_data,
  input  logic                       i_last,
  output logic                       o_ready,
  output logic [ROWS*(DATA_W+1)-1:0] o_west_data,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int CNT_W = $clog2(ROWS) + 1;
  localparam int SL_W  = DATA_W + 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] drain_cnt;
  logic             acc_p0;

  assign acc_p0 = i_valid & o_ready;

  // Stage p0 -> p(r+1): per-row skew shift registers. They advance every
  // cycle; a cycle without an accepted beat pushes a zero bubble so later
  // beats keep their diagonal alignment.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [SL_W-1:0] in_p0;
    logic [(r+1)*SL_W-1:0] sr_p1;

    assign in_p0 = acc_p0 ? {1'b1, i_data[(ROWS-r)*DATA_W-1 -: DATA_W]} : '0;

    if (r == 0) begin : g_d1
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          sr_p1 <= '0;
        end else begin
          sr_p1 <= in_p0;
        end
      end
    end else begin : g_dn
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          sr_p1 <= '0;
        end else begin
          sr_p1 <= {sr_p1[r*SL_W-1:0], in_p0};
        end
      end
    end

    // Oldest entry sits at the top of the packed shift register.
    assign o_west_data[(ROWS-r)*SL_W-1 -: SL_W] = sr_p1[(r+1)*SL_W-1 -: SL_W];
  end

  // Tile control. Outputs are registered alongside the state so they change
  // on the same edge as the state they describe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      drain_cnt <= '0;
      o_ready   <= 1'b1;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        IDLE, STREAM: begin
          if (acc_p0) begin
            o_busy <= 1'b1;
            if (i_last) begin
              // The last beat still needs ROWS cycles to clear the deepest row.
              state     <= DRAIN;
              drain_cnt <= CNT_W'(ROWS - 1);
              o_ready   <= 1'b0;
            end else begin
              state <= STREAM;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state  <= DONE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - CNT_W'(1);
          end
        end
        DONE: begin
          state   <= IDLE;
          o_ready <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          o_ready <= 1'b1;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_west_skew_feeder.sv
module tb_west_skew_feeder;

  localparam int ROWS = 9;
  localparam int DW   = 8;
  localparam int SW   = DW + 1;
  localparam int HN   = 4096;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 i_valid = 1'b0;
  logic [ROWS*DW-1:0]   i_data = '0;
  logic                 i_last = 1'b0;
  logic                 o_ready;
  logic [ROWS*SW-1:0]   o_west_data;
  logic                 o_busy;
  logic                 o_done;

  logic                 v1 = 1'b0;
  logic [DW-1:0]        d1 = '0;
  logic                 l1 = 1'b0;
  logic                 ready1;
  logic [SW-1:0]        west1;
  logic                 busy1;
  logic                 done1;

  int vectors = 0;
  int miscompares = 0;

  west_skew_feeder #(.ROWS(ROWS), .DATA_W(DW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .i_data(i_data),
    .i_last(i_last), .o_ready(o_ready), .o_west_data(o_west_data),
    .o_busy(o_busy), .o_done(o_done)
  );

  west_skew_feeder #(.ROWS(1), .DATA_W(DW)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(v1), .i_data(d1),
    .i_last(l1), .o_ready(ready1), .o_west_data(west1),
    .o_busy(busy1), .o_done(done1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [ROWS*SW-1:0] act,
                     input logic [ROWS*SW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // History of accepted beats by cycle number; row r at cycle t shows the
  // beat accepted at cycle t-r-1. Tile phase follows from the cycle of the
  // last beat: drain for ROWS cycles, done on the next, ready again after.
  int  cyc = 0;
  int  floor_c = 0;
  int  last_c = -1;
  bit  open_t = 0;
  bit  acc_h [HN];
  logic [ROWS*DW-1:0] dat_h [HN];
  bit  exp_ready = 1, exp_busy = 0, exp_done = 0;

  initial for (int i = 0; i < HN; i++) begin acc_h[i] = 0; dat_h[i] = '0; end

  always @(posedge clk) begin
    int t;
    bit a;
    if (!rst_n) begin
      acc_h[cyc % HN] = 0;
      floor_c = cyc + 1;
      last_c = -1;
      open_t = 0;
    end else begin
      a = i_valid && exp_ready;
      acc_h[cyc % HN] = a;
      dat_h[cyc % HN] = i_data;
      if (a) begin
        if (i_last) begin last_c = cyc; open_t = 0; end
        else open_t = 1;
      end
    end
    t = cyc + 1;
    if (last_c >= 0 && t > last_c + ROWS + 1) last_c = -1;
    exp_ready = (last_c < 0);
    exp_done  = (last_c >= 0) && (t == last_c + ROWS + 1);
    exp_busy  = open_t || ((last_c >= 0) && (t <= last_c + ROWS));
    cyc = t;
  end

  always @(negedge rst_n) begin
    floor_c = cyc;
    last_c = -1;
    open_t = 0;
    exp_ready = 1;
    exp_busy = 0;
    exp_done = 0;
  end

  function automatic logic [ROWS*SW-1:0] model_west(int t);
    logic [ROWS*SW-1:0] v;
    int idx;
    v = '0;
    for (int r = 0; r < ROWS; r++) begin
      idx = t - r - 1;
      if (idx >= 0 && idx >= floor_c && acc_h[idx % HN])
        v[(ROWS-r)*SW-1 -: SW] = {1'b1, dat_h[idx % HN][(ROWS-r)*DW-1 -: DW]};
    end
    return v;
  endfunction

  function automatic logic [SW-1:0] row_of(logic [ROWS*SW-1:0] v, int r);
    return v[(ROWS-r)*SW-1 -: SW];
  endfunction

  always @(negedge clk) begin
    chk("west_data", o_west_data, model_west(cyc));
    chk("ready", {80'b0, o_ready}, {80'b0, exp_ready});
    chk("busy",  {80'b0, o_busy},  {80'b0, exp_busy});
    chk("done",  {80'b0, o_done},  {80'b0, exp_done});
  end

  // ---------------- directed stimulus ----------------
  task automatic at_cycle(input int n);
    while (cyc < n) @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [ROWS*DW-1:0] d, input logic l);
    i_valid = 1'b1; i_data = d; i_last = l;
    @(posedge clk); #1;
    i_valid = 1'b0; i_data = '0; i_last = 1'b0;
  endtask

  localparam logic [ROWS*DW-1:0] D1 = 72'h010203040506070809;
  localparam logic [ROWS*DW-1:0] D2 = 72'h112233445566778899;

  initial begin
    int c0;
    logic [7:0] b;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {80'b0, o_ready}, {80'b0, 1'b1});
    chk("rst_west", o_west_data, '0);
    chk("rst_busy", {80'b0, o_busy}, '0);
    chk("rst_done", {80'b0, o_done}, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // single-beat tile
    c0 = cyc;
    send(D1, 1'b1);
    at_cycle(c0 + 1);
    chk("t1_ready_lo", {80'b0, o_ready}, '0);
    for (int r = 0; r < ROWS; r++) begin
      at_cycle(c0 + r + 1);
      chk("t1_row", {72'b0, row_of(o_west_data, r)}, {72'b0, 1'b1, 8'(r + 1)});
    end
    at_cycle(c0 + 10);
    chk("t1_done", {80'b0, o_done}, {80'b0, 1'b1});
    at_cycle(c0 + 12);

    // four back-to-back beats
    c0 = cyc;
    send({ROWS{8'h10}}, 1'b0);
    send({ROWS{8'h20}}, 1'b0);
    send({ROWS{8'h30}}, 1'b0);
    send({ROWS{8'h40}}, 1'b1);
    at_cycle(c0 + 9);
    chk("t2_row8_first", {72'b0, row_of(o_west_data, 8)}, {72'b0, 9'h110});
    at_cycle(c0 + 12);
    chk("t2_row8_last", {72'b0, row_of(o_west_data, 8)}, {72'b0, 9'h140});
    chk("t2_no_early_done", {80'b0, o_done}, '0);
    at_cycle(c0 + 13);
    chk("t2_done", {80'b0, o_done}, {80'b0, 1'b1});
    at_cycle(c0 + 15);

    // beat, bubble, beat
    c0 = cyc;
    send({ROWS{8'h5A}}, 1'b0);
    @(posedge clk); #1;
    send({ROWS{8'hC3}}, 1'b1);
    at_cycle(c0 + 4);
    chk("t3_row3_a", {72'b0, row_of(o_west_data, 3)}, {72'b0, 9'h15A});
    at_cycle(c0 + 5);
    chk("t3_row3_bub", {72'b0, row_of(o_west_data, 3)}, '0);
    at_cycle(c0 + 6);
    chk("t3_row3_b", {72'b0, row_of(o_west_data, 3)}, {72'b0, 9'h1C3});
    at_cycle(c0 + 14);

    // i_valid held through drain and done
    c0 = cyc;
    i_valid = 1'b1; i_data = D1; i_last = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      b = 8'(k * 17 + 3);
      i_data = {ROWS{b}};
      i_last = k[0];
      if (k == 5) chk("t4_ready_lo", {80'b0, o_ready}, '0);
    end
    @(posedge clk); #1;
    i_valid = 1'b0; i_last = 1'b0; i_data = '0;
    at_cycle(c0 + 14);

    // reset pulse mid-drain, then restart with a beat on the first edge
    c0 = cyc;
    send(D2, 1'b1);
    at_cycle(c0 + 4);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_west", o_west_data, '0);
    chk("t5_async_ready", {80'b0, o_ready}, {80'b0, 1'b1});
    @(posedge clk); #1;
    rst_n = 1'b1;
    c0 = cyc;
    send(D1, 1'b1);
    at_cycle(c0 + 1);
    chk("t5_row0", {72'b0, row_of(o_west_data, 0)}, {72'b0, 9'h101});
    at_cycle(c0 + 10);
    chk("t5_done", {80'b0, o_done}, {80'b0, 1'b1});
    at_cycle(c0 + 13);

    // ROWS=1 instance
    c0 = cyc;
    v1 = 1'b1; d1 = 8'hAA; l1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0; l1 = 1'b0; d1 = '0;
    at_cycle(c0 + 1);
    chk("r1_west", {72'b0, west1}, {72'b0, 9'h1AA});
    chk("r1_ready_lo", {80'b0, ready1}, '0);
    chk("r1_no_done", {80'b0, done1}, '0);
    at_cycle(c0 + 2);
    chk("r1_done", {80'b0, done1}, {80'b0, 1'b1});
    chk("r1_west_clear", {72'b0, west1}, '0);
    at_cycle(c0 + 3);
    chk("r1_ready_hi", {80'b0, ready1}, {80'b0, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
